// File: rtl/pollard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pollard_pkg
//  Description : Shared types and constants for the Pollard p-1 datapath
//                blocks (prime power finder, exponent accumulator, GCD unit).
//  Revision    : 1.0 - initial release
// ============================================================================
package pollard_pkg;

  // Default operand width for the Pollard blocks
  localparam int POLLARD_W = 16;

  // Control states for the prime power finder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // With base >= 2 the exponent never exceeds w-1, so this is always enough
  function automatic int exp_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prime_power_finder.sv
`default_nettype none
// ============================================================================
//  Module      : prime_power_finder
//  Description : Finds e = floor(log_p B) and p^e by repeated multiplication,
//                one multiply/compare per cycle, with start/busy/done handshake
//                and an error flag for degenerate operands (p < 2 or B == 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_power_finder
  import pollard_pkg::*;
#(
  parameter  int W     = POLLARD_W,
  localparam int EXP_W = exp_width(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     boundary,
  input  logic [W-1:0]     base,
  output logic             busy,
  output logic             done,
  output logic [EXP_W-1:0] exponent,
  output logic [W-1:0]     power,
  output logic             err
);

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_base;
  logic [W-1:0]     r_bound;
  logic [W-1:0]     r_power;
  logic [EXP_W-1:0] r_exp;
  logic [2*W-1:0]   w_prod;
  logic             w_fit;
  logic             w_bad;

  // The product is formed at double width so the compare is exact even when
  // the next power would exceed 2^W; r_power <= B keeps it from overflowing.
  assign w_prod = {{W{1'b0}}, r_power} * {{W{1'b0}}, r_base};
  assign w_fit  = (w_prod <= {{W{1'b0}}, r_bound});
  assign w_bad  = (base < W'(2)) || (boundary == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: degenerate operands skip RUN; DONE always lasts one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = w_bad ? DONE : RUN;
      end
      RUN: begin
        if (!w_fit) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, iterate in RUN, publish results on
  // the edge that enters DONE so they stay stable until the next completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base   <= '0;
      r_bound  <= '0;
      r_power  <= W'(1);
      r_exp    <= '0;
      exponent <= '0;
      power    <= W'(1);
      err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base  <= base;
            r_bound <= boundary;
            r_power <= W'(1);
            r_exp   <= '0;
            if (w_bad) begin
              exponent <= '0;
              power    <= W'(1);
              err      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_fit) begin
            r_power <= w_prod[W-1:0];
            r_exp   <= r_exp + EXP_W'(1);
          end else begin
            exponent <= r_exp;
            power    <= r_power;
            err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prime_power_finder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_power_finder
//  Description : Directed self-checking bench for prime_power_finder at W=16
//                and W=32, with a scoreboard of expected results and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_power_finder;

  typedef struct {
    logic [63:0] e;
    logic [63:0] pw;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start16 = 1'b0;
  logic [15:0] base16  = '0;
  logic [15:0] bound16 = '0;
  logic        busy16, done16, err16;
  logic [4:0]  exponent16;
  logic [15:0] power16;

  logic        start32 = 1'b0;
  logic [31:0] base32  = '0;
  logic [31:0] bound32 = '0;
  logic        busy32, done32, err32;
  logic [5:0]  exponent32;
  logic [31:0] power32;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  prime_power_finder #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .boundary(bound16), .base(base16),
    .busy(busy16), .done(done16), .exponent(exponent16), .power(power16), .err(err16)
  );

  prime_power_finder #(.W(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .boundary(bound32), .base(base32),
    .busy(busy32), .done(done32), .exponent(exponent32), .power(power32), .err(err32)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] f_exp(input bit wide);
    return wide ? 64'(exponent32) : 64'(exponent16);
  endfunction
  function automatic logic [63:0] f_pw(input bit wide);
    return wide ? 64'(power32) : 64'(power16);
  endfunction
  function automatic logic f_done(input bit wide);
    return wide ? done32 : done16;
  endfunction
  function automatic logic f_busy(input bit wide);
    return wide ? busy32 : busy16;
  endfunction
  function automatic logic f_err(input bit wide);
    return wide ? err32 : err16;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_in(input bit wide, input logic s, input logic [31:0] p, input logic [31:0] b);
    if (wide) begin
      start32 = s; base32 = p; bound32 = b;
    end else begin
      start16 = s; base16 = p[15:0]; bound16 = b[15:0];
    end
  endtask

  task automatic push(input logic [63:0] e, input logic [63:0] pw, input logic err);
    exp_t x;
    x.e = e; x.pw = pw; x.err = err;
    x.lat = err ? 0 : int'(e) + 1;
    sb.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input bit wide, input logic [31:0] p, input logic [31:0] b,
                        input logic [63:0] e, input logic [63:0] pw, input logic err,
                        input bit hold);
    push(e, pw, err);
    set_in(wide, 1'b1, p, b);
    @(negedge clk);
    if (!hold) set_in(wide, 1'b0, $urandom, $urandom);
  endtask

  // Waits for done, pops the scoreboard and checks results, latency, busy
  // length and that done is a single-cycle pulse. Optionally re-pulses start
  // with other operands at iteration pulse_at.
  task automatic collect(input bit wide, input string name, input int pulse_at,
                         input logic [31:0] pp, input logic [31:0] pb);
    exp_t x;
    int   k    = 0;
    int   nb   = 0;
    bit   seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pulse_at >= 0 && i == pulse_at)     set_in(wide, 1'b1, pp, pb);
      if (pulse_at >= 0 && i == pulse_at + 1) set_in(wide, 1'b0, pp, pb);
      if (f_done(wide)) begin
        seen = 1'b1;
        k = i;
        break;
      end
      if (f_busy(wide)) nb++;
      @(negedge clk);
    end
    if (pulse_at >= 0) set_in(wide, 1'b0, pp, pb);
    check({name, ".done_seen"}, 64'(seen), 64'(1));
    if (seen && sb.size() > 0) begin
      x = sb.pop_front();
      check({name, ".latency"},  64'(k),            64'(x.lat));
      check({name, ".busy_len"}, 64'(nb),           64'(x.lat));
      check({name, ".exponent"}, f_exp(wide),       x.e);
      check({name, ".power"},    f_pw(wide),        x.pw);
      check({name, ".err"},      64'(f_err(wide)),  64'(x.err));
      @(negedge clk);
      check({name, ".done_pulse"}, 64'(f_done(wide)), 64'(0));
    end
  endtask

  // Directed sequence
  initial begin
    @(negedge clk);
    check("reset.busy",     64'(busy16),  64'(0));
    check("reset.done",     64'(done16),  64'(0));
    check("reset.exponent", f_exp(0),     64'(0));
    check("reset.power",    f_pw(0),      64'(1));
    check("reset.err",      64'(err16),   64'(0));
    rst = 1'b0;
    @(negedge clk);

    launch(0, 2, 100, 6, 64, 0, 0);          collect(0, "p2_b100", -1, 0, 0);
    launch(0, 3, 81, 4, 81, 0, 0);           collect(0, "p3_b81", -1, 0, 0);
    launch(0, 1, 50, 0, 1, 1, 0);            collect(0, "p1_b50", -1, 0, 0);
    launch(0, 5, 4, 0, 1, 0, 0);             collect(0, "p5_b4", -1, 0, 0);
    launch(0, 0, 0, 0, 1, 1, 0);             collect(0, "p0_b0", -1, 0, 0);
    launch(0, 7, 0, 0, 1, 1, 0);             collect(0, "p7_b0", -1, 0, 0);
    launch(0, 2, 65535, 15, 32768, 0, 0);    collect(0, "p2_bmax", -1, 0, 0);
    launch(0, 65521, 65535, 1, 65521, 0, 0); collect(0, "p65521", -1, 0, 0);

    // start re-pulsed while busy with other operands is ignored
    launch(0, 2, 100, 6, 64, 0, 0);          collect(0, "repulse", 2, 3, 81);

    // start held high: back-to-back runs with a one-cycle IDLE gap
    launch(0, 3, 81, 4, 81, 0, 1);           collect(0, "held1", -1, 0, 0);
    check("held.gap_busy", 64'(busy16), 64'(0));
    push(4, 81, 0);
    @(negedge clk);
    check("held.second_busy", 64'(busy16), 64'(1));
    collect(0, "held2", -1, 0, 0);
    set_in(0, 1'b0, 0, 0);

    // asynchronous reset mid-run, with non-reset results held beforehand
    launch(0, 3, 81, 4, 81, 0, 0);           collect(0, "pre_rst", -1, 0, 0);
    set_in(0, 1'b1, 2, 1000);
    @(negedge clk);
    set_in(0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    check("midrun.busy", 64'(busy16), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("arst.busy",     64'(busy16), 64'(0));
    check("arst.done",     64'(done16), 64'(0));
    check("arst.exponent", f_exp(0),    64'(0));
    check("arst.power",    f_pw(0),     64'(1));
    check("arst.err",      64'(err16),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(0, 2, 1000, 9, 512, 0, 0);        collect(0, "post_rst", -1, 0, 0);

    // 32-bit instance at the top of its range
    launch(1, 2, 32'hFFFF_FFFF, 31, 64'h8000_0000, 0, 0);
    collect(1, "w32_p2_bmax", -1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire

// File: doc/prime_power_finder.md
Name: prime_power_finder

Overview:
- For one prime p and smoothness bound B, computes e = floor(log_p B), the largest e with p^e <= B, and the prime power p^e.
- Feeds the Pollard p-1 exponent accumulator, which multiplies the p^e terms into M.
- Parametrised successor of the fixed-width exponent finder:
  - generic width;
  - start/busy/done handshake;
  - returns the power as well as the exponent;
  - exact "<=" semantics, with no overflow at any width;
  - error flag for degenerate operands.

Parameters:
- W, 16, width of boundary, base and power.
- EXP_W, $clog2(W)+1 (derived localparam, not overridable), width of exponent; with base >= 2, e <= W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- boundary  in  W  bound B; captured on accepted start.
- base  in  W  prime p; captured on accepted start.
- busy  out  1  high from the edge after an accepted start until the edge that raises done.
- done  out  1  single-cycle completion pulse.
- exponent  out  EXP_W  result e; held until the next accepted start.
- power  out  W  result p^e; held until the next accepted start.
- err  out  1  degenerate-operand flag; valid with done, held like the results.

Behaviour:
- Reset values: busy=0, done=0, exponent=0, power=1, err=0, state=IDLE.
- Reset asserted mid-operation aborts the run; all outputs return to reset values.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures B and p into internal registers; power_r=1, exp_r=0.
  - If p<2 or B==0: set err=1, go to DONE.
  - Else: err=0, go to RUN.
- RUN, one iteration per cycle:
  - prod = power_r * p_r, computed in 2W bits; cannot overflow, since power_r <= B < 2^W.
  - If prod <= B: power_r <= prod[W-1:0], exp_r <= exp_r+1, stay in RUN.
  - Else: go to DONE.
- DONE: lasts one cycle with done=1, busy=0; then IDLE.
- exponent and power outputs update on the edge that enters DONE.
- Latency, counted from the edge sampling start (edge N):
  - valid operands: done is high in the cycle after edge N+e+1;
  - err case: done is high in the cycle after edge N.
- start while busy or in DONE is ignored and not queued.
- start held continuously: a new run is accepted on the first IDLE cycle after DONE.
- Inputs need only be stable on the accepting edge; later changes have no effect.
- Equality counts: p^e == B yields that e.
- When err=1: exponent=0, power=1.
- Combinational compare/multiply only; no combinational path from inputs to outputs.

Decomposition:
- Package pollard_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - default width constant POLLARD_W=16;
  - helper function exp_width(W) used for EXP_W.
- The package is shared with the exponent accumulator and the GCD unit.
- No sub-module; a single FSM plus datapath in one module. The multiplier is an inferred operator.

Test Plan:
- W=16, p=2, B=100, start at edge N -> e=6, power=64, err=0, done high only in the cycle after edge N+7, busy high for 7 cycles.
- p=3, B=81 -> e=4, power=81 (equality included). p=5, B=4 -> e=0, power=1, err=0, done after edge N+1.
- p=1, B=50 -> err=1, e=0, power=1, done after edge N. p=0, B=0 -> err=1. p=7, B=0 -> err=1.
- Width extremes, W=16:
  - p=2, B=65535 -> e=15, power=32768, no wrap.
  - p=65521, B=65535 -> e=1.
  - W=32, p=2, B=2^32-1 -> e=31.
- Handshake:
  - start re-pulsed while busy with different operands -> ignored; first result unchanged.
  - start held high -> back-to-back runs, one-cycle IDLE gap each.
- Reset:
  - rst asserted asynchronously mid-RUN (p=2, B=1000, 4 cycles in) -> outputs immediately at reset values.
  - Next start gives a clean e=9, power=512.
